sc_jug_move_ctrl: RTL



---
 rtl/sc_jug_pkg.sv | 30 +++
 rtl/sc_btn_debounce.sv | 48 ++++
 rtl/sc_jug_move_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/sc_jug_pkg.sv
// Shared definitions for the jug movement control path: shift codes understood
// by the player position register, FSM state encoding and direction decode.
package sc_jug_pkg;

    // Shift-selection codes consumed by the player register
    localparam logic [1:0] SHIFT_NONE  = 2'b00;
    localparam logic [1:0] SHIFT_LEFT  = 2'b01;
    localparam logic [1:0] SHIFT_RIGHT = 2'b10;

    // Per-direction press / auto-repeat FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WAIT   = 2'b01,
        ST_REPEAT = 2'b10
    } move_state_e;

    // Both buttons or neither cancel each other out, so 11 can never appear
    function automatic logic [1:0] dir_code(input logic left_pressed,
                                            input logic right_pressed);
        logic [1:0] code;
        code = SHIFT_NONE;
        if (left_pressed && !right_pressed) begin
            code = SHIFT_LEFT;
        end else if (right_pressed && !left_pressed) begin
            code = SHIFT_RIGHT;
        end
        return code;
    endfunction

endpackage

// File: rtl/sc_btn_debounce.sv
// Two-flop synchroniser plus level debouncer for one active-low pushbutton.
// The debounced level only follows the synchronised level after it has
// differed continuously for DEBOUNCE_CYCLES clocks.
module sc_btn_debounce
    import sc_jug_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_WIDTH       = 25
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_n_i,
    output logic pressed_o
);

    localparam logic [CNT_WIDTH-1:0] DEB_LIMIT = CNT_WIDTH'(DEBOUNCE_CYCLES);

    logic                 sync1_q;
    logic                 sync2_q;
    logic                 level_n_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    // Synchronise the raw pin and accept a new level once it has been stable long enough
    always_ff @(posedge clk_i) begin
        // NOTE: reset is sampled on the clock edge, so it sits inside the clocked branch, not in the sensitivity list.
        if (!rst_ni) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            level_n_q <= 1'b1;
            cnt_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments make sync2_q take the old sync1_q, giving two real flops.
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
            if (sync2_q == level_n_q) begin
                cnt_q <= '0;
            end else if (cnt_q == DEB_LIMIT) begin
                level_n_q <= sync2_q;
                cnt_q     <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign pressed_o = ~level_n_q;

endmodule

// File: rtl/sc_jug_move_ctrl.sv
// Turns the left/right pushbuttons into single-cycle shift pulses for the
// player position register: one pulse per press, then auto-repeat pulses
// after REPEAT_DELAY and every REPEAT_PERIOD while the button stays held.
module sc_jug_move_ctrl
    import sc_jug_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 20000000,
    parameter int unsigned REPEAT_PERIOD   = 7500000,
    parameter int unsigned CNT_WIDTH       = 25
) (
    input  logic       SC_JugMove_CLOCK_50,
    input  logic       SC_JugMove_RESET_InLow,
    input  logic       SC_JugMove_left_InLow,
    input  logic       SC_JugMove_right_InLow,
    input  logic       SC_JugMove_enable_InHigh,
    output logic [1:0] SC_JugMove_shiftselection_Out,
    output logic       SC_JugMove_held_Out
);

    // Timer reload values: the timer counts down to zero inclusive
    localparam logic [CNT_WIDTH-1:0] DELAY_RELOAD  = CNT_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] PERIOD_RELOAD = CNT_WIDTH'(REPEAT_PERIOD - 1);

    logic                 left_pressed;
    logic                 right_pressed;
    logic [1:0]           dir;

    move_state_e          state_q;
    logic [1:0]           latched_q;
    logic [1:0]           shift_q;
    logic                 held_q;
    logic [CNT_WIDTH-1:0] timer_q;

    sc_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_left_deb (
        .clk_i    (SC_JugMove_CLOCK_50),
        .rst_ni   (SC_JugMove_RESET_InLow),
        .btn_n_i  (SC_JugMove_left_InLow),
        .pressed_o(left_pressed)
    );

    sc_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_right_deb (
        .clk_i    (SC_JugMove_CLOCK_50),
        .rst_ni   (SC_JugMove_RESET_InLow),
        .btn_n_i  (SC_JugMove_right_InLow),
        .pressed_o(right_pressed)
    );

    assign dir = dir_code(left_pressed, right_pressed);

    // Press / auto-repeat FSM with registered pulse and held outputs
    always_ff @(posedge SC_JugMove_CLOCK_50) begin
        if (!SC_JugMove_RESET_InLow) begin
            state_q   <= ST_IDLE;
            latched_q <= SHIFT_NONE;
            timer_q   <= '0;
            shift_q   <= SHIFT_NONE;
            held_q    <= 1'b0;
        end else begin
            // Pulses last one cycle; every branch that does not pulse leaves 00
            shift_q <= SHIFT_NONE;
            held_q  <= (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (dir != SHIFT_NONE && SC_JugMove_enable_InHigh) begin
                        shift_q   <= dir;
                        latched_q <= dir;
                        timer_q   <= DELAY_RELOAD;
                        state_q   <= ST_WAIT;
                    end
                end
                ST_WAIT, ST_REPEAT: begin
                    // A direction change or pause drops back; a new direction fires from IDLE
                    if (dir != latched_q || !SC_JugMove_enable_InHigh) begin
                        state_q <= ST_IDLE;
                    end else if (timer_q == '0) begin
                        shift_q <= latched_q;
                        timer_q <= PERIOD_RELOAD;
                        state_q <= ST_REPEAT;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign SC_JugMove_shiftselection_Out = shift_q;
    assign SC_JugMove_held_Out           = held_q;

endmodule
